vga_timing_gen: RTL and testbench

- Parametrised raster timing generator. Successor to the fixed 640x480 VGA controller.
- Produces h/v counters, programmable-polarity sync signals, blanking, and line/frame start strobes.
- Also produces a look-ahead fetch coordinate, so a framebuffer or ROM with LEAD cycles of read latency delivers pixel data aligned with (x,y).
- Sits between the pixel clock and the pixel-source/colour-output stage.

---
 rtl/vga_timing_gen.sv | 125 ++++++++++++
 tb/tb_vga_timing_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: h/v counters, sync, blanking, line/frame strobes,
// and a look-ahead fetch coordinate that leads (x,y) by LEAD raster steps.
module vga_timing_gen #(
    parameter int CW        = 11,
    parameter int HACTIVE   = 640,
    parameter int HFP       = 16,
    parameter int HSYN      = 96,
    parameter int HBP       = 48,
    parameter int VACTIVE   = 480,
    parameter int VFP       = 10,
    parameter int VSYN      = 2,
    parameter int VBP       = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int LEAD      = 2
) (
    input  logic          vgaclk,
    input  logic          rst_n,
    input  logic          en,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          hsync,
    output logic          vsync,
    output logic          sync_b,
    output logic          blank_b,
    output logic          line_start,
    output logic          frame_start,
    output logic [CW-1:0] fetch_x,
    output logic [CW-1:0] fetch_y,
    output logic          fetch_valid
);

    localparam int HMAX  = HACTIVE + HFP + HSYN + HBP;
    localparam int VMAX  = VACTIVE + VFP + VSYN + VBP;
    localparam int HS_LO = HACTIVE + HFP;
    localparam int HS_HI = HS_LO + HSYN;
    localparam int VS_LO = VACTIVE + VFP;
    localparam int VS_HI = VS_LO + VSYN;

    localparam logic [CW-1:0] X_LAST = CW'(HMAX - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(VMAX - 1);

    // Reset parks (x,y) on the last blanked position; fetch sits LEAD steps beyond it.
    localparam int FX_I = (LEAD == 0) ? HMAX - 1 : LEAD - 1;
    localparam int FY_I = (LEAD == 0) ? VMAX - 1 : 0;
    localparam logic [CW-1:0] FX_RST = CW'(FX_I);
    localparam logic [CW-1:0] FY_RST = CW'(FY_I);
    localparam bit FV_RST = (FX_I < HACTIVE) && (FY_I < VACTIVE);

    if (HMAX > (1 << CW) || VMAX > (1 << CW)) begin : g_bad_cw
        $error("vga_timing_gen: HMAX/VMAX do not fit in CW bits");
    end
    if (LEAD < 0 || LEAD > HFP + HSYN + HBP) begin : g_bad_lead
        $error("vga_timing_gen: LEAD outside 0..HFP+HSYN+HBP");
    end

    typedef struct packed {
        logic [CW-1:0] h;
        logic [CW-1:0] v;
    } pos_t;

    function automatic pos_t advance(input pos_t p);
        pos_t n;
        n = p;
        if (p.h == X_LAST) begin
            n.h = '0;
            n.v = (p.v == Y_LAST) ? '0 : p.v + 1'b1;
        end else begin
            n.h = p.h + 1'b1;
        end
        return n;
    endfunction

    function automatic logic below(input logic [CW-1:0] v, input int unsigned lim);
        return 32'(v) < lim;
    endfunction

    function automatic logic in_win(input logic [CW-1:0] v, input int unsigned lo,
                                    input int unsigned hi);
        return (32'(v) >= lo) && (32'(v) < hi);
    endfunction

    pos_t nxt, fnxt;
    logic hs_act, vs_act;

    // NOTE: status is decoded from the next position so the registered flags line up
    // with the registered (x,y) they describe, without any output-side logic.
    always_comb begin
        nxt    = advance({x, y});
        fnxt   = advance({fetch_x, fetch_y});
        hs_act = in_win(nxt.h, HS_LO, HS_HI);
        vs_act = in_win(nxt.v, VS_LO, VS_HI);
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge vgaclk) begin
        if (!rst_n) begin
            x           <= X_LAST;
            y           <= Y_LAST;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            sync_b      <= 1'b1;
            blank_b     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            fetch_x     <= FX_RST;
            fetch_y     <= FY_RST;
            fetch_valid <= FV_RST;
        end else if (en) begin
            x           <= nxt.h;
            y           <= nxt.v;
            hsync       <= hs_act ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= vs_act ? VSYNC_POL : ~VSYNC_POL;
            sync_b      <= ~(hs_act | vs_act);
            blank_b     <= below(nxt.h, HACTIVE) & below(nxt.v, VACTIVE);
            line_start  <= (nxt.h == '0);
            frame_start <= (nxt.h == '0) & (nxt.v == '0);
            fetch_x     <= fnxt.h;
            fetch_y     <= fnxt.v;
            fetch_valid <= below(fnxt.h, HACTIVE) & below(fnxt.v, VACTIVE);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: three configurations compared against a
// linear raster-index model through a one-deep expected-value scoreboard.
module tb_vga_timing_gen;

    typedef struct {
        logic [31:0] x, y, fx, fy;
        logic        hs, vs, sb, bb, ls, fs, fv;
    } obs_t;

    typedef struct {
        int ha, hfp, hsy, hbp, va, vfp, vsy, vbp, hpol, vpol, lead;
    } cfg_t;

    logic vgaclk = 1'b0;
    always #5 vgaclk = ~vgaclk;

    logic rst_n0 = 1'b1, en0 = 1'b0;
    logic rst_n1 = 1'b1, en1 = 1'b0;
    logic rst_n2 = 1'b1, en2 = 1'b0;

    logic [10:0] x0, y0, fx0, fy0, x1, y1, fx1, fy1;
    logic [3:0]  x2, y2, fx2, fy2;
    logic hs0, vs0, sb0, bb0, ls0, fs0, fv0;
    logic hs1, vs1, sb1, bb1, ls1, fs1, fv1;
    logic hs2, vs2, sb2, bb2, ls2, fs2, fv2;

    vga_timing_gen d0 (
        .vgaclk(vgaclk), .rst_n(rst_n0), .en(en0), .x(x0), .y(y0),
        .hsync(hs0), .vsync(vs0), .sync_b(sb0), .blank_b(bb0),
        .line_start(ls0), .frame_start(fs0),
        .fetch_x(fx0), .fetch_y(fy0), .fetch_valid(fv0)
    );

    vga_timing_gen #(
        .CW(11), .HACTIVE(800), .HFP(40), .HSYN(128), .HBP(88),
        .VACTIVE(600), .VFP(1), .VSYN(4), .VBP(23),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .LEAD(0)
    ) d1 (
        .vgaclk(vgaclk), .rst_n(rst_n1), .en(en1), .x(x1), .y(y1),
        .hsync(hs1), .vsync(vs1), .sync_b(sb1), .blank_b(bb1),
        .line_start(ls1), .frame_start(fs1),
        .fetch_x(fx1), .fetch_y(fy1), .fetch_valid(fv1)
    );

    // Tiny raster so whole frames, vsync and fetch frame-wrap are cheap to cover.
    vga_timing_gen #(
        .CW(4), .HACTIVE(8), .HFP(2), .HSYN(3), .HBP(2),
        .VACTIVE(6), .VFP(1), .VSYN(2), .VBP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .LEAD(7)
    ) d2 (
        .vgaclk(vgaclk), .rst_n(rst_n2), .en(en2), .x(x2), .y(y2),
        .hsync(hs2), .vsync(vs2), .sync_b(sb2), .blank_b(bb2),
        .line_start(ls2), .frame_start(fs2),
        .fetch_x(fx2), .fetch_y(fy2), .fetch_valid(fv2)
    );

    int   checks   = 0;
    int   failures = 0;
    int   p [3];
    obs_t sb_q [$];

    function automatic cfg_t cfg_of(input int i);
        cfg_t c;
        case (i)
            0:       c = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2};
            1:       c = '{800, 40, 128, 88, 600, 1, 4, 23, 1, 1, 0};
            default: c = '{8, 2, 3, 2, 6, 1, 2, 1, 1, 0, 7};
        endcase
        return c;
    endfunction

    function automatic int hmax_of(input int i);
        cfg_t c = cfg_of(i);
        return c.ha + c.hfp + c.hsy + c.hbp;
    endfunction

    function automatic int total_of(input int i);
        cfg_t c = cfg_of(i);
        return hmax_of(i) * (c.va + c.vfp + c.vsy + c.vbp);
    endfunction

    // Expected outputs for raster index pos (0 = top-left of the frame).
    function automatic obs_t model(input int i, input int pos);
        cfg_t c = cfg_of(i);
        obs_t e;
        int hm, q, xx, yy, fxx, fyy;
        bit ha, va;
        hm  = hmax_of(i);
        xx  = pos % hm;
        yy  = pos / hm;
        q   = (pos + c.lead) % total_of(i);
        fxx = q % hm;
        fyy = q / hm;
        ha  = (xx >= c.ha + c.hfp) && (xx < c.ha + c.hfp + c.hsy);
        va  = (yy >= c.va + c.vfp) && (yy < c.va + c.vfp + c.vsy);
        e.x  = 32'(xx);
        e.y  = 32'(yy);
        e.fx = 32'(fxx);
        e.fy = 32'(fyy);
        e.hs = ha ? c.hpol[0] : ~c.hpol[0];
        e.vs = va ? c.vpol[0] : ~c.vpol[0];
        e.sb = !(ha || va);
        e.bb = (xx < c.ha) && (yy < c.va);
        e.ls = (xx == 0);
        e.fs = (xx == 0) && (yy == 0);
        e.fv = (fxx < c.ha) && (fyy < c.va);
        return e;
    endfunction

    function automatic obs_t observe(input int i);
        obs_t g;
        case (i)
            0: g = '{32'(x0), 32'(y0), 32'(fx0), 32'(fy0), hs0, vs0, sb0, bb0, ls0, fs0, fv0};
            1: g = '{32'(x1), 32'(y1), 32'(fx1), 32'(fy1), hs1, vs1, sb1, bb1, ls1, fs1, fv1};
            default:
               g = '{32'(x2), 32'(y2), 32'(fx2), 32'(fy2), hs2, vs2, sb2, bb2, ls2, fs2, fv2};
        endcase
        return g;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic cmp_all(input int i, input obs_t g, input obs_t e);
        string t;
        t = $sformatf("d%0d@%0d", i, p[i]);
        cmp({t, "_x"},  g.x,  e.x);
        cmp({t, "_y"},  g.y,  e.y);
        cmp({t, "_fx"}, g.fx, e.fx);
        cmp({t, "_fy"}, g.fy, e.fy);
        cmp({t, "_hsync"},       32'(g.hs), 32'(e.hs));
        cmp({t, "_vsync"},       32'(g.vs), 32'(e.vs));
        cmp({t, "_sync_b"},      32'(g.sb), 32'(e.sb));
        cmp({t, "_blank_b"},     32'(g.bb), 32'(e.bb));
        cmp({t, "_line_start"},  32'(g.ls), 32'(e.ls));
        cmp({t, "_frame_start"}, 32'(g.fs), 32'(e.fs));
        cmp({t, "_fetch_valid"}, 32'(g.fv), 32'(e.fv));
    endtask

    // One clock for instance i; the other instances hold (en=0).
    task automatic cycle(input int i, input bit r, input bit e);
        obs_t ex;
        rst_n0 = 1'b1; en0 = 1'b0;
        rst_n1 = 1'b1; en1 = 1'b0;
        rst_n2 = 1'b1; en2 = 1'b0;
        case (i)
            0:       begin rst_n0 = r; en0 = e; end
            1:       begin rst_n1 = r; en1 = e; end
            default: begin rst_n2 = r; en2 = e; end
        endcase
        if (!r)     p[i] = total_of(i) - 1;
        else if (e) p[i] = (p[i] + 1) % total_of(i);
        sb_q.push_back(model(i, p[i]));
        @(posedge vgaclk);
        #1;
        ex = sb_q.pop_front();
        cmp_all(i, observe(i), ex);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) p[i] = 0;

        // Default timing: reset wins over en=1, then first step lands on (0,0).
        cycle(0, 1'b0, 1'b1);
        cmp("d0_rst_x", 32'(x0), 32'd799);
        cmp("d0_rst_fetch_x", 32'(fx0), 32'd1);
        cycle(0, 1'b1, 1'b1);
        cmp("d0_first_frame_start", 32'(fs0), 32'd1);
        cmp("d0_first_fetch_x", 32'(fx0), 32'd2);
        for (int k = 0; k < 100; k++) cycle(0, 1'b1, 1'b1);
        cycle(0, 1'b1, 1'b1);
        cycle(0, 1'b1, 1'b0);
        cycle(0, 1'b1, 1'b0);
        cmp("d0_hold_x", 32'(x0), 32'd101);
        cycle(0, 1'b1, 1'b1);
        cmp("d0_resume_x", 32'(x0), 32'd102);

        // Finish line 0 and stall on x==0 of line 1.
        while (p[0] != 800) cycle(0, 1'b1, 1'b1);
        cmp("d0_wrap_y", 32'(y0), 32'd1);
        cycle(0, 1'b1, 1'b0);
        cycle(0, 1'b1, 1'b0);
        cmp("d0_stall_line_start", 32'(ls0), 32'd1);

        // Fetch leads across the line wrap.
        while (p[0] != 10 * 800 + 798) cycle(0, 1'b1, 1'b1);
        cmp("d0_lead_fetch_x", 32'(fx0), 32'd0);
        cmp("d0_lead_fetch_y", 32'(fy0), 32'd11);
        cmp("d0_lead_fetch_valid", 32'(fv0), 32'd1);

        // Alternate timing: mid-frame reset with en=1, LEAD=0.
        cycle(1, 1'b0, 1'b0);
        for (int k = 0; k < 3 * 1056 + 501; k++) cycle(1, 1'b1, 1'b1);
        cmp("d1_mid_x", 32'(x1), 32'd500);
        cycle(1, 1'b0, 1'b1);
        cmp("d1_reset_x", 32'(x1), 32'd1055);
        cmp("d1_reset_fetch_y", 32'(fy1), 32'd627);
        for (int k = 0; k < 1100; k++) cycle(1, 1'b1, 1'b1);

        // Small raster: multiple frames, random stalls, one reset mid-run.
        cycle(2, 1'b0, 1'b0);
        for (int k = 0; k < 400; k++) begin
            if (k == 230) cycle(2, 1'b0, 1'b1);
            else          cycle(2, 1'b1, $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
